// File: rtl/rr_fifo_arbiter_pkg.sv
// rtl/rr_fifo_arbiter_pkg.sv - shared FSM encoding and destination helpers for rr_fifo_arbiter
package rr_fifo_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2
  } arb_state_e;

  localparam int DEST_W    = 2;
  localparam int DEST_NUM  = 1 << DEST_W;

  function automatic logic [DEST_NUM-1:0] dest_onehot(input logic [DEST_W-1:0] dest);
    return DEST_NUM'(1) << dest;
  endfunction

endpackage

// File: rtl/rr_fifo_arbiter_pick.sv
// rtl/rr_fifo_arbiter_pick.sv - rotate-priority encoder: first requester after ptr, skipping excl
module rr_fifo_arbiter_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic [N-1:0]  excl_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic [PW-1:0] cand;
  logic          found;

  // Scan ptr+1 .. ptr+N so the pointer itself has the lowest priority.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = PW'((int'(ptr_i) + k) % N);
      if (!found && req_i[cand] && !excl_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        found         = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// rtl/rr_fifo_arbiter.sv - round-robin drain of source FIFOs into destination FIFOs by dest field
module rr_fifo_arbiter
  import rr_fifo_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = 12,
  parameter int NUM_SRC   = 4,
  parameter int NUM_DST   = 4,
  parameter int CNT_W     = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_SRC-1:0]            src_empty_i,
  input  logic [NUM_SRC-1:0]            src_valid_i,
  input  logic [NUM_SRC*DATA_SIZE-1:0]  src_data_i,
  input  logic [NUM_DST-1:0]            dst_almost_full_i,
  output logic [NUM_SRC-1:0]            src_read_o,
  output logic [NUM_DST-1:0]            dst_write_o,
  output logic [DATA_SIZE-1:0]          dst_data_o,
  output logic [1:0]                    state_o,
  output logic                          arb_error_o,
  output logic [CNT_W-1:0]              fwd_count_o
);

  localparam int PW = $clog2(NUM_SRC);

  arb_state_e           state_q, state_d;
  logic [PW-1:0]        ptr_q;
  logic [NUM_SRC-1:0]   src_read_q;
  logic [NUM_SRC-1:0]   rd_prev_q;
  logic [NUM_DST-1:0]   dst_write_q, dst_write_d;
  logic [DATA_SIZE-1:0] dst_data_q;
  logic                 err_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 any_nonempty;
  logic                 any_af;
  logic [NUM_SRC-1:0]   pick_grant;
  logic [PW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 pop;

  logic [NUM_SRC-1:0]   good_valid;
  logic [NUM_SRC-1:0]   bad_valid;
  logic                 cap_valid;
  logic [DATA_SIZE-1:0] cap_data;
  logic [DEST_W-1:0]    cap_dest;

  assign any_nonempty = ~&src_empty_i;
  assign any_af       = |dst_almost_full_i;

  // The source read this cycle is excluded: its empty flag has not caught up yet.
  rr_fifo_arbiter_pick #(
    .N  (NUM_SRC),
    .PW (PW)
  ) u_pick (
    .req_i   (~src_empty_i),
    .ptr_i   (ptr_q),
    .excl_i  (src_read_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign pop = (state_q == ST_ACTIVE) && !any_af && pick_any;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_nonempty && !any_af) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (any_af)             state_d = ST_PAUSE;
        else if (!any_nonempty) state_d = ST_IDLE;
      end
      ST_PAUSE: begin
        if (!any_af) state_d = any_nonempty ? ST_ACTIVE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only a valid that answers last cycle's strobe is a real word; anything else is discarded.
  assign good_valid = src_valid_i & rd_prev_q;
  assign bad_valid  = src_valid_i & ~rd_prev_q;

  always_comb begin
    cap_valid = 1'b0;
    cap_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (good_valid[i]) begin
        cap_valid = 1'b1;
        cap_data  = src_data_i[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  assign cap_dest    = cap_data[DATA_SIZE-1 -: DEST_W];
  assign dst_write_d = cap_valid ? NUM_DST'(dest_onehot(cap_dest)) : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PW'(NUM_SRC - 1);
      src_read_q  <= '0;
      rd_prev_q   <= '0;
      dst_write_q <= '0;
      dst_data_q  <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      src_read_q  <= pop ? pick_grant : '0;
      rd_prev_q   <= src_read_q;
      dst_write_q <= dst_write_d;
      if (pop) ptr_q <= pick_idx;
      if (cap_valid) begin
        dst_data_q <= cap_data;
        cnt_q      <= cnt_q + 1'b1;
      end
      if (|bad_valid) err_q <= 1'b1;
    end
  end

  assign src_read_o  = src_read_q;
  assign dst_write_o = dst_write_q;
  assign dst_data_o  = dst_data_q;
  assign state_o     = state_q;
  assign arb_error_o = err_q;
  assign fwd_count_o = cnt_q;

endmodule
